mips_multicycle_ctrl: RTL

Main control FSM for the multi-cycle MIPS datapath. It sequences the shared 32-bit ALU, instruction register, register file, memory port and PC through fetch, decode, execute, memory and write-back steps. Every ALU operation in the core is therefore selected here. It decodes opcode/funct from the instruction register and drives all datapath enables and mux selects, including the 4-bit ALU control code.

---
 rtl/mips_pkg.sv | 67 ++++++
 rtl/mips_multicycle_ctrl_alu_decoder.sv | 24 ++
 rtl/mips_multicycle_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs, ALU codes,
// FSM state encoding, datapath select constants and the control-word struct.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [3:0] ALU_AND = 4'd0;
   localparam logic [3:0] ALU_OR  = 4'd1;
   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_SUB = 4'd6;
   localparam logic [3:0] ALU_SLT = 4'd7;
   localparam logic [3:0] ALU_NOR = 4'd12;

   localparam logic [1:0] ALUB_RT    = 2'b00;
   localparam logic [1:0] ALUB_FOUR  = 2'b01;
   localparam logic [1:0] ALUB_IMM   = 2'b10;
   localparam logic [1:0] ALUB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTEXE   = 4'd6,
      S_RTWB    = 4'd7,
      S_BEQ     = 4'd8,
      S_ADDIEXE = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

   // One packed word for every datapath control, so gating and defaults are single assignments.
   typedef struct packed {
      logic       pcen;
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       irwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [3:0] aluco;
      logic [1:0] pcsrc;
      logic       illegal;
   } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// Combinational R-type funct decode: ALU control code plus a flag for supported functs.
module alu_decoder
   import mips_pkg::*;
(
   input  logic [5:0] funct,
   output logic [3:0] aluco,
   output logic       funct_valid
);

   always_comb begin
      aluco       = ALU_ADD;
      funct_valid = 1'b1;
      case (funct)
         FN_ADD:  aluco = ALU_ADD;
         FN_SUB:  aluco = ALU_SUB;
         FN_AND:  aluco = ALU_AND;
         FN_OR:   aluco = ALU_OR;
         FN_NOR:  aluco = ALU_NOR;
         FN_SLT:  aluco = ALU_SLT;
         default: funct_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main multi-cycle MIPS control FSM: state register, next-state logic and Moore output
// decode (aluco in RTEXE follows funct, pcen in BEQ follows zero).
module mips_multicycle_ctrl
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcen,
   output logic       iord,
   output logic       memread,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [3:0] aluco,
   output logic [1:0] pcsrc,
   output logic       illegal
);

   state_t     state_q;
   state_t     state_d;
   ctrl_t      ctrl;
   ctrl_t      ctrl_gated;
   logic [3:0] rt_aluco;
   logic       funct_valid;

   alu_decoder u_alu_decoder (
      .funct       (funct),
      .aluco       (rt_aluco),
      .funct_valid (funct_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = S_FETCH;
      ctrl       = '0;
      ctrl.aluco = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            ctrl.memread = 1'b1;
            ctrl.irwrite = 1'b1;
            ctrl.alusrcb = ALUB_FOUR;
            ctrl.pcsrc   = PCSRC_ALU;
            ctrl.pcen    = 1'b1;
            state_d      = S_DECODE;
         end
         S_DECODE: begin
            // Branch target is computed speculatively here into ALUOut.
            ctrl.alusrcb = ALUB_IMMSH;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_BEQ:       state_d = S_BEQ;
               OP_ADDI:      state_d = S_ADDIEXE;
               OP_J:         state_d = S_JUMP;
               OP_RTYPE: begin
                  if (funct_valid) state_d = S_RTEXE;
                  else             ctrl.illegal = 1'b1;
               end
               default: ctrl.illegal = 1'b1;
            endcase
         end
         S_MEMADR: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = ALUB_IMM;
            state_d      = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            ctrl.iord    = 1'b1;
            ctrl.memread = 1'b1;
            state_d      = S_MEMWB;
         end
         S_MEMWB: begin
            ctrl.regwrite = 1'b1;
            ctrl.memtoreg = 1'b1;
         end
         S_MEMWR: begin
            ctrl.iord     = 1'b1;
            ctrl.memwrite = 1'b1;
         end
         S_RTEXE: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = ALUB_RT;
            ctrl.aluco   = rt_aluco;
            state_d      = S_RTWB;
         end
         S_RTWB: begin
            ctrl.regwrite = 1'b1;
            ctrl.regdst   = 1'b1;
         end
         S_BEQ: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = ALUB_RT;
            ctrl.aluco   = ALU_SUB;
            ctrl.pcsrc   = PCSRC_ALUOUT;
            ctrl.pcen    = zero;
         end
         S_ADDIEXE: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = ALUB_IMM;
            state_d      = S_ADDIWB;
         end
         S_ADDIWB: begin
            ctrl.regwrite = 1'b1;
         end
         S_JUMP: begin
            ctrl.pcsrc = PCSRC_JUMP;
            ctrl.pcen  = 1'b1;
         end
         default: begin
            // Unreachable encodings recover to FETCH with every control quiet.
            ctrl    = '0;
            state_d = S_FETCH;
         end
      endcase
   end

   // Reset gates the outputs immediately so nothing strobes while rst_n is low.
   assign ctrl_gated = rst_n ? ctrl : '0;

   assign pcen     = ctrl_gated.pcen;
   assign iord     = ctrl_gated.iord;
   assign memread  = ctrl_gated.memread;
   assign memwrite = ctrl_gated.memwrite;
   assign irwrite  = ctrl_gated.irwrite;
   assign regdst   = ctrl_gated.regdst;
   assign memtoreg = ctrl_gated.memtoreg;
   assign regwrite = ctrl_gated.regwrite;
   assign alusrca  = ctrl_gated.alusrca;
   assign alusrcb  = ctrl_gated.alusrcb;
   assign aluco    = ctrl_gated.aluco;
   assign pcsrc    = ctrl_gated.pcsrc;
   assign illegal  = ctrl_gated.illegal;

endmodule
